// File: rtl/belief_sched_pkg.sv
// Shared constants for the LLR stage-update sequencer: function select codes,
// controller state encoding and the LLR saturation bound.
package belief_sched_pkg;

    localparam int SIZE_DEF = 8;

    localparam logic FUNC_F = 1'b0;
    localparam logic FUNC_G = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int llr_max_of(input int size);
        return (1 << (size - 1)) - 1;
    endfunction

    localparam int LLR_MAX = llr_max_of(SIZE_DEF);

endpackage

// File: rtl/belief_sched_g_belief.sv
// g-function: b+a or b-a on already-conditioned LLRs, computed one bit wider
// and saturated to the symmetric range +/-LLR_MAX.
module g_belief
    import belief_sched_pkg::*;
#(
    parameter int SIZE = SIZE_DEF
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            u,
    output logic [SIZE-1:0] y
);
    localparam int MAX_I = llr_max_of(SIZE);
    localparam logic signed [SIZE:0] SAT_POS = (SIZE+1)'(MAX_I);
    localparam logic signed [SIZE:0] SAT_NEG = -SAT_POS;

    logic signed [SIZE:0] a_w;
    logic signed [SIZE:0] b_w;
    logic signed [SIZE:0] sum_w;

    assign a_w   = {a[SIZE-1], a};
    assign b_w   = {b[SIZE-1], b};
    assign sum_w = u ? (b_w - a_w) : (b_w + a_w);

    always_comb begin
        y = sum_w[SIZE-1:0];
        if (sum_w > SAT_POS) begin
            y = SAT_POS[SIZE-1:0];
        end else if (sum_w < SAT_NEG) begin
            y = SAT_NEG[SIZE-1:0];
        end
    end

endmodule

// File: rtl/belief_sched.sv
// Walks one tree node's LLR halves, applies f (min-sum) or g through a shared
// two-stage datapath and writes the results to the destination region.
module belief_sched
    import belief_sched_pkg::*;
#(
    parameter int SIZE = SIZE_DEF,
    parameter int AW   = 10,
    parameter int LW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            func,
    input  logic [LW-1:0]   log_half,
    input  logic [AW-1:0]   src_base,
    input  logic [AW-1:0]   dst_base,
    input  logic            hold,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr_a,
    output logic [AW-1:0]   rd_addr_b,
    input  logic [SIZE-1:0] rd_data_a,
    input  logic [SIZE-1:0] rd_data_b,
    output logic [AW-1:0]   ps_addr,
    input  logic            ps_bit,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [SIZE-1:0] wr_data,
    output logic            busy,
    output logic            done
);
    localparam logic [SIZE-1:0] LLR_MIN_RAW = {1'b1, {(SIZE-1){1'b0}}};
    localparam logic [SIZE-1:0] LLR_NEG_MAX = {1'b1, {(SIZE-2){1'b0}}, 1'b1};
    localparam logic [SIZE-1:0] ONE_S       = {{(SIZE-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]   ONE_A       = {{(AW-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            func_q;
    logic [AW-1:0]   half_q;
    logic [AW-1:0]   src_q;
    logic [AW-1:0]   dst_q;
    logic            accept;

    logic            p0_valid_q;
    logic [AW-1:0]   p0_idx_q;
    logic            wr_en_q;
    logic [AW-1:0]   wr_addr_q;
    logic [SIZE-1:0] wr_data_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rd_en   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!hold) begin
                    rd_en = 1'b1;
                    idx_d = idx_q + ONE_A;
                    if (idx_q == half_q - ONE_A) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            // The result leaving stage 1 this cycle is the last one once no read is in flight.
            ST_DRAIN: begin
                if (!p0_valid_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rd_addr_a = src_q + idx_q;
    assign rd_addr_b = src_q + half_q + idx_q;
    assign ps_addr   = idx_q;
    assign busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

    // The most negative code has no positive twin, so fold it onto -LLR_MAX first.
    logic [SIZE-1:0] a_c, b_c, mag_a, mag_b, f_mag, f_res, g_res, result;

    assign a_c   = (rd_data_a == LLR_MIN_RAW) ? LLR_NEG_MAX : rd_data_a;
    assign b_c   = (rd_data_b == LLR_MIN_RAW) ? LLR_NEG_MAX : rd_data_b;
    assign mag_a = a_c[SIZE-1] ? (~a_c + ONE_S) : a_c;
    assign mag_b = b_c[SIZE-1] ? (~b_c + ONE_S) : b_c;
    assign f_mag = (mag_a < mag_b) ? mag_a : mag_b;
    assign f_res = (a_c[SIZE-1] ^ b_c[SIZE-1]) ? (~f_mag + ONE_S) : f_mag;

    g_belief #(.SIZE(SIZE)) u_g_belief (
        .a (a_c),
        .b (b_c),
        .u (ps_bit),
        .y (g_res)
    );

    assign result = (func_q == FUNC_G) ? g_res : f_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            func_q     <= FUNC_F;
            half_q     <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            p0_valid_q <= 1'b0;
            p0_idx_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                func_q <= func;
                half_q <= ONE_A << log_half;
                src_q  <= src_base;
                dst_q  <= dst_base;
            end
            p0_valid_q <= rd_en;
            if (rd_en) begin
                p0_idx_q <= idx_q;
            end
            wr_en_q <= p0_valid_q;
            if (p0_valid_q) begin
                wr_addr_q <= dst_q + p0_idx_q;
                wr_data_q <= result;
            end
        end
    end

endmodule
